// File: rtl/tmng_pkg.sv
// Shared types and constants for the time-multiplexed NAND scheduler.
package tmng_pkg;

  localparam logic MODE_TDM = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int unsigned NUM_REQ_DEFAULT = 4;

  typedef struct packed {
    logic valid;
    logic a;
    logic b;
  } slot_t;

endpackage

// File: rtl/tmng_rr_pick.sv
// Cyclic priority picker: first set request at or after start, wrapping around.
module tmng_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = IDX_W'((32'(start) + 32'(k)) % NUM_REQ);
      if (req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/tmng_scheduler.sv
// Time-multiplexes one registered NAND unit among NUM_REQ requesters using
// one-entry operand slots and a TDM or round-robin grant.
module tmng_scheduler
  import tmng_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               mode,
  input  logic [NUM_REQ-1:0] issue,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  input  logic               ovf_clr,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] result,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic [NUM_REQ-1:0] overflow,
  output logic [CNT_W-1:0]   op_count
);

  slot_t [NUM_REQ-1:0] slot_q;
  logic  [NUM_REQ-1:0] slot_valid;
  logic                exec_valid_q, exec_a_q, exec_b_q;
  logic  [IDX_W-1:0]   grant_idx_q;
  logic  [NUM_REQ-1:0] done_q, result_q;
  logic  [NUM_REQ-1:0] overflow_q, overflow_d;
  logic  [CNT_W-1:0]   op_count_q;
  logic  [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic  [IDX_W-1:0]   tdm_ctr_q, tdm_ctr_d;

  logic                rr_found;
  logic  [IDX_W-1:0]   rr_idx;
  logic                grant_vld;
  logic  [IDX_W-1:0]   grant_sel;
  logic  [NUM_REQ-1:0] grant_oh;
  logic  [NUM_REQ-1:0] accept;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + IDX_W'(1);
  endfunction

  tmng_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req   (slot_valid),
    .start (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_valid[i] = slot_q[i].valid;
    end
    grant_vld = ena & ((mode == MODE_RR) ? rr_found : slot_valid[tdm_ctr_q]);
    grant_sel = (mode == MODE_RR) ? rr_idx : tdm_ctr_q;
    grant_oh  = '0;
    if (grant_vld) begin
      grant_oh[grant_sel] = 1'b1;
    end
    // A slot being granted this cycle frees up in time to take a new issue.
    accept     = issue & (~slot_valid | grant_oh);
    overflow_d = (overflow_q & ~{NUM_REQ{ovf_clr}}) | (issue & ~accept);
    tdm_ctr_d  = ena ? wrap_inc(tdm_ctr_q) : tdm_ctr_q;
    rr_ptr_d   = (grant_vld && (mode == MODE_RR)) ? wrap_inc(rr_idx) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      exec_valid_q <= 1'b0;
      exec_a_q     <= 1'b0;
      exec_b_q     <= 1'b0;
      grant_idx_q  <= '0;
      done_q       <= '0;
      result_q     <= '0;
      overflow_q   <= '0;
      op_count_q   <= '0;
      rr_ptr_q     <= '0;
      tdm_ctr_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_q[i] <= slot_t'{valid: 1'b1, a: op_a[i], b: op_b[i]};
        end else if (grant_oh[i]) begin
          slot_q[i].valid <= 1'b0;
        end
      end

      exec_valid_q <= grant_vld;
      if (grant_vld) begin
        exec_a_q    <= slot_q[grant_sel].a;
        exec_b_q    <= slot_q[grant_sel].b;
        grant_idx_q <= grant_sel;
      end

      done_q <= '0;
      if (exec_valid_q) begin
        done_q[grant_idx_q]   <= 1'b1;
        result_q[grant_idx_q] <= ~(exec_a_q & exec_b_q);
        op_count_q            <= op_count_q + CNT_W'(1);
      end

      overflow_q <= overflow_d;
      tdm_ctr_q  <= tdm_ctr_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign grant_idx = grant_idx_q;
  assign busy      = (|slot_valid) | exec_valid_q;
  assign overflow  = overflow_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_tmng_scheduler.sv
// Directed bench for tmng_scheduler with a scoreboard of expected completions.
module tb_tmng_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena, mode, ovf_clr;
  logic [NUM_REQ-1:0] issue, op_a, op_b;
  logic [NUM_REQ-1:0] done, result, overflow;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;
  logic [CNT_W-1:0]   op_count;

  tmng_scheduler #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .mode      (mode),
    .issue     (issue),
    .op_a      (op_a),
    .op_b      (op_b),
    .ovf_clr   (ovf_clr),
    .done      (done),
    .result    (result),
    .grant_idx (grant_idx),
    .busy      (busy),
    .overflow  (overflow),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic res;
    int   cyc;  // -1: completion cycle not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   t0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input int idx, input logic a, input logic b, input int c);
    exp_t e;
    e.idx = idx;
    e.res = ~(a & b);
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    step(1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    issue   = '0;
    ovf_clr = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_idx", 32'(done), 32'(1) << e.idx);
        check("done_result", 32'(result[e.idx]), 32'(e.res));
        if (e.cyc >= 0) check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; mode = 1'b1; ovf_clr = 1'b0;
    issue = '0; op_a = '0; op_b = '0;
    step(1);
    do_reset();

    // Single operation latency, RR mode
    t0 = cyc;
    issue = 4'b0100; op_a = 4'b0100; op_b = 4'b0100;
    expect_op(2, 1'b1, 1'b1, t0 + 3);
    step(1);
    issue = '0;
    step(1);
    check("t1_grant_idx", 32'(grant_idx), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    step(1);
    check("t1_op_count", 32'(op_count), 32'd1);
    drain();

    // Round-robin fairness from rr_ptr=0
    do_reset();
    t0 = cyc;
    issue = 4'b1111; op_a = '0; op_b = '0;
    for (int i = 0; i < 4; i++) expect_op(i, 1'b0, 1'b0, t0 + 3 + i);
    step(1);
    issue = '0;
    step(5);
    check("t2_op_count", 32'(op_count), 32'd4);
    drain();

    // TDM wait: issue while tdm_ctr=1
    do_reset();
    mode = 1'b0;
    step(1);
    t0 = cyc;
    issue = 4'b0001; op_a = 4'b0001; op_b = 4'b0000;
    expect_op(0, 1'b1, 1'b0, t0 + 5);
    step(1);
    issue = '0;
    step(3);
    check("t3_busy_exec", 32'(busy), 32'd1);
    drain();

    // Overflow with ena low, then clear
    mode = 1'b1;
    ena  = 1'b0;
    t0 = cyc;
    issue = 4'b0010; op_a = 4'b0010; op_b = 4'b0010;
    expect_op(1, 1'b1, 1'b1, t0 + 6);
    step(1);
    issue = '0;
    step(1);
    issue = 4'b0010; op_a = '0; op_b = '0;
    step(1);
    issue = '0;
    check("t4_overflow_set", 32'(overflow), 32'h2);
    check("t4_busy_pending", 32'(busy), 32'd1);
    step(1);
    ena = 1'b1;
    drain();
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("t4_overflow_clr", 32'(overflow), 32'd0);

    // Overflow beats a simultaneous clear
    ena = 1'b0;
    issue = 4'b0001; op_a = 4'b0001; op_b = 4'b0001;
    expect_op(0, 1'b1, 1'b1, -1);
    step(1);
    issue = 4'b0001; op_a = '0; op_b = '0; ovf_clr = 1'b1;
    step(1);
    issue = '0; ovf_clr = 1'b0;
    check("t4_overflow_wins", 32'(overflow), 32'h1);
    ena = 1'b1;
    drain();
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;

    // Re-issue in the grant cycle
    t0 = cyc;
    issue = 4'b1000; op_a = 4'b1000; op_b = 4'b1000;
    expect_op(3, 1'b1, 1'b1, t0 + 3);
    step(1);
    op_b = 4'b0000;
    expect_op(3, 1'b1, 1'b0, t0 + 4);
    step(1);
    issue = '0;
    drain();
    check("t5_no_overflow", 32'(overflow), 32'd0);

    // Counter wrap: 255 back-to-back ops on requester 0, then one more
    do_reset();
    for (int n = 0; n < 255; n++) begin
      issue = 4'b0001; op_a = 4'b0001; op_b = 4'b0001;
      expect_op(0, 1'b1, 1'b1, cyc + 3);
      step(1);
    end
    issue = '0;
    drain();
    check("t6_op_count_255", 32'(op_count), 32'd255);
    check("t6_no_overflow", 32'(overflow), 32'd0);
    issue = 4'b0100; op_a = 4'b0000; op_b = 4'b0100;
    expect_op(2, 1'b0, 1'b1, cyc + 3);
    step(1);
    issue = '0;
    drain();
    check("t6_op_count_wrap", 32'(op_count), 32'd0);

    // Reset while the execute stage holds an operation
    issue = 4'b0010; op_a = '0; op_b = '0;
    step(1);
    issue = '0;
    step(1);
    check("t6_busy_inflight", 32'(busy), 32'd1);
    do_reset();
    step(6);
    check("t6_post_rst_count", 32'(op_count), 32'd0);
    check("t6_post_rst_result", 32'(result), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmng_scheduler.md
Name: tmng_scheduler

Overview:
- Shares one registered NAND evaluation unit among NUM_REQ requesters by time multiplexing.
- Each requester issues a single-cycle operation pulse, which is captured in a one-entry per-requester slot.
- A scheduler grants one slot per cycle, in either fixed TDM order or work-conserving round-robin order, and returns the result with a done pulse.
- Sits between the pin-level input synchronisers/edge detectors and the shared NAND execution stage in the top-level design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), requester index width.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ena  in  1  scheduler enable. When low, no new grants are made.
- mode  in  1  0 = TDM, 1 = round-robin.
- issue  in  NUM_REQ  per-requester single-cycle operation request.
- op_a  in  NUM_REQ  operand A per requester; sampled only when issue[i]=1.
- op_b  in  NUM_REQ  operand B per requester; sampled only when issue[i]=1.
- ovf_clr  in  1  clears all overflow flags.
- done  out  NUM_REQ  one-cycle completion pulse per requester.
- result  out  NUM_REQ  last NAND result per requester; held until the next completion for that requester.
- grant_idx  out  IDX_W  index of the operation currently in the execute stage.
- busy  out  1  high when any slot is valid or the execute stage is valid.
- overflow  out  NUM_REQ  sticky flag: an issue was dropped for that requester.
- op_count  out  CNT_W  total completed operations; wraps.

Behaviour:
- Reset (async, rst_n=0) clears:
  - slot_valid, exec_valid, done, result, overflow, op_count, grant_idx → 0.
  - rr_ptr → 0, tdm_ctr → 0.
- Accept rule: issue[i] at cycle t is accepted if slot_valid[i]=0, or if slot i is granted in cycle t.
  - On accept: slot_valid[i]=1 and operands are latched at the end of cycle t.
  - Otherwise the issue is dropped and overflow[i] is set.
  - ovf_clr and a new overflow on the same cycle: overflow wins (flag stays set).
- Grant (combinational, cycle t), only when ena=1:
  - RR mode: lowest-index valid slot at or after rr_ptr (cyclic search). After a grant, rr_ptr ← winner+1 mod NUM_REQ.
  - TDM mode: candidate is tdm_ctr only; grant if slot_valid[tdm_ctr].
- tdm_ctr advances mod NUM_REQ every ena=1 cycle, in either mode.
- With ena=0: no grant; rr_ptr and tdm_ctr hold; accepts continue; the in-flight execute stage still completes.
- Grant effect at the end of cycle t:
  - Winner's slot_valid is cleared (unless re-accepted the same cycle).
  - exec_valid ← 1, exec_a/exec_b ← slot operands, grant_idx ← winner.
- Execute, cycle t+1:
  - At the end of the cycle, if exec_valid: result[grant_idx] ← ~(exec_a & exec_b), done[grant_idx] ← 1 for exactly one cycle, op_count ← op_count+1 (wraps 2^CNT_W-1 → 0).
  - exec_valid ← next grant (pipelined; one completion per cycle sustained).
- Latency from issue at cycle t to done:
  - Minimum: done high in cycle t+3 (slot at t+1, exec at t+2, done at t+3).
  - Maximum in RR: t+2+NUM_REQ.
  - Maximum in TDM: t+2+NUM_REQ.
- Mode switch takes effect on the next grant decision. Pending slots are never lost. rr_ptr is retained across mode switches.
- Reset mid-operation: all pending and in-flight operations are discarded. No done pulse is produced for them.
- grant_idx holds its last value while exec_valid=0.

Decomposition:
- Package tmng_pkg holds:
  - MODE_TDM=1'b0, MODE_RR=1'b1.
  - Default NUM_REQ.
  - typedef slot_t {valid, a, b}.
- Sub-module tmng_rr_pick: purely combinational cyclic priority picker.
  - Inputs: req vector, start pointer.
  - Outputs: found, idx.
  - Instantiated once; the TDM path is inline.

Test Plan:
- Single operation latency: RR mode, ena=1, issue[2]=1 with a=1,b=1 at cycle 0 → done[2] in cycle 3, result[2]=0, op_count=1, grant_idx=2 during cycle 2.
- Round-robin fairness: RR mode, rr_ptr=0, issue=4'b1111 with all operands 0 at cycle 0 → done pulses for requesters 0,1,2,3 in cycles 3,4,5,6, every result=1, op_count=4.
- TDM wait: TDM mode, tdm_ctr=1 at the issue cycle, issue[0] at cycle 0 → granted when tdm_ctr=0, at cycle 3 → done[0] in cycle 5.
- Overflow and clear:
  - ena=0, issue[1] at cycles 0 and 2 → overflow[1]=1, with only the first operation retained.
  - Raise ena at cycle 4 → one done[1].
  - ovf_clr → overflow[1]=0.
- Re-issue on grant cycle: issue[3] accepted in the same cycle its slot is granted → two done[3] pulses in consecutive cycles, each carrying its own operands.
- Reset mid-op plus counter wrap:
  - Preload op_count=255 via 255 operations, complete one more → op_count=0.
  - Assert rst_n=0 while exec_valid=1 → no done pulse; all outputs 0 asynchronously.
